// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

  localparam int unsigned MODE_CT = 0;
  localparam int unsigned MODE_SF = 1;

  typedef enum logic {
    PASS,
    DROP
  } wr_state_e;

  // Pointers carry one extra wrap bit; full when they are exactly one lap apart.
  function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                    input int unsigned depth);
    logic [31:0] diff;
    diff = wr - rd;
    return (diff & ((depth << 1) - 1)) == depth;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat bundle with master/slave views.
interface axis_pkt_fifo_if #(
  parameter int unsigned DATA_WIDTH = 512
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, array not reset.
module axis_fifo_sdp_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream packet buffer with cut-through or store-and-forward release and
// oversize-packet dropping in store-and-forward mode.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned SF_MODE    = MODE_CT
) (
  input  logic                   aclk,
  input  logic                   areset,
  axis_pkt_fifo_if.slave         s_axis,
  axis_pkt_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   drop_pulse
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned RAM_W  = DATA_WIDTH + KEEP_W + 1;

  typedef logic [ADDR_W:0] ptr_t;

  ptr_t       wr_ptr_q, wr_commit_q, rd_ptr_q;
  wr_state_e  state_q;
  logic       in_pkt_q;
  logic       m_valid_q;
  logic       full, s_hs, wr_en, avail, load;
  logic [RAM_W-1:0] rd_word;

  assign full = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), DEPTH);

  // Ready comes only from registered pointers, so a same-cycle read never reopens a full FIFO.
  assign s_axis.tready = !areset && ((state_q == DROP) || !full);
  assign s_hs          = s_axis.tvalid && s_axis.tready;
  assign wr_en         = s_hs && (state_q == PASS);

  assign avail = rd_ptr_q != wr_commit_q;
  assign load  = avail && (!m_valid_q || m_axis.tready);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      state_q     <= PASS;
      in_pkt_q    <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      unique case (state_q)
        PASS: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            in_pkt_q <= !s_axis.tlast;
            if ((SF_MODE == MODE_CT) || s_axis.tlast) begin
              wr_commit_q <= wr_ptr_q + 1'b1;
            end
          end else if ((SF_MODE == MODE_SF) && full && (rd_ptr_q == wr_commit_q) && in_pkt_q)
          begin
            // RAM holds nothing but an unfinished packet: rewind and discard the rest of it.
            state_q    <= DROP;
            wr_ptr_q   <= wr_commit_q;
            drop_pulse <= 1'b1;
          end
        end
        DROP: begin
          if (s_hs && s_axis.tlast) begin
            state_q  <= PASS;
            in_pkt_q <= 1'b0;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

  // The RAM's registered read port doubles as the one-entry output register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
    end else if (load) begin
      rd_ptr_q  <= rd_ptr_q + 1'b1;
      m_valid_q <= 1'b1;
    end else if (m_axis.tready) begin
      m_valid_q <= 1'b0;
    end
  end

  axis_fifo_sdp_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
    .re_i    (load),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_word)
  );

  assign m_axis.tdata  = rd_word[DATA_WIDTH-1:0];
  assign m_axis.tkeep  = rd_word[DATA_WIDTH +: KEEP_W];
  assign m_axis.tlast  = rd_word[RAM_W-1];
  assign m_axis.tvalid = m_valid_q;

  assign occupancy = wr_ptr_q - rd_ptr_q;

endmodule
